// File: rtl/vwiden_if.sv
// Handshake bundle between the vALU issue stage, the widen beat sequencer and the downstream ALU lanes.
interface vwiden_if #(
  parameter int REQ_DATA_WIDTH    = 64,
  parameter int SEW_WIDTH         = 2,
  parameter int REQ_BYTE_EN_WIDTH = 8
);
  logic                         req_valid;
  logic                         req_ready;
  logic [REQ_DATA_WIDTH-1:0]    req_vec0;
  logic [REQ_DATA_WIDTH-1:0]    req_vec1;
  logic [SEW_WIDTH-1:0]         req_sew;
  logic                         req_signed;
  logic                         req_widen;
  logic [REQ_BYTE_EN_WIDTH-1:0] req_be;

  logic [REQ_DATA_WIDTH-1:0]    wid_vec0;
  logic [REQ_DATA_WIDTH-1:0]    wid_vec1;
  logic [SEW_WIDTH-1:0]         wid_sew;
  logic                         wid_signed;
  logic [REQ_BYTE_EN_WIDTH-1:0] wid_be;
  logic                         wid_turn;
  logic                         out_valid;
  logic                         out_ready;
  logic                         out_last;
  logic                         out_illegal;

  modport master (
    output req_valid, req_vec0, req_vec1, req_sew, req_signed, req_widen, req_be, out_ready,
    input  req_ready, wid_vec0, wid_vec1, wid_sew, wid_signed, wid_be, wid_turn,
           out_valid, out_last, out_illegal
  );

  modport slave (
    input  req_valid, req_vec0, req_vec1, req_sew, req_signed, req_widen, req_be, out_ready,
    output req_ready, wid_vec0, wid_vec1, wid_sew, wid_signed, wid_be, wid_turn,
           out_valid, out_last, out_illegal
  );
endinterface

// File: rtl/vwiden_seq.sv
// Beat sequencer: splits a widening request into low/high half beats for the widen unit.
module vwiden_seq (
  input logic    clk,
  input logic    rst,
  vwiden_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LO, HI} state_t;

  localparam logic [1:0] SEW_64 = 2'd3;

  state_t state;
  logic   widen_eff;
  logic   out_valid;
  logic   out_last;
  logic   out_illegal;
  logic   wid_turn;
  logic   req_ready;
  logic   accept;
  logic   beat_done;

  assign beat_done = out_valid & bus.out_ready;
  assign req_ready = ~rst & ((state == IDLE) | (beat_done & out_last));
  assign accept    = bus.req_valid & req_ready;

  assign bus.req_ready   = req_ready;
  assign bus.out_valid   = out_valid;
  assign bus.out_last    = out_last;
  assign bus.out_illegal = out_illegal;
  assign bus.wid_turn    = wid_turn;

  // A new request can only be accepted in IDLE or on the final beat, so capture takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      widen_eff      <= 1'b0;
      out_valid      <= 1'b0;
      out_last       <= 1'b0;
      out_illegal    <= 1'b0;
      wid_turn       <= 1'b0;
      bus.wid_vec0   <= '0;
      bus.wid_vec1   <= '0;
      bus.wid_sew    <= '0;
      bus.wid_signed <= 1'b0;
      bus.wid_be     <= '0;
    end else if (accept) begin
      state          <= LO;
      widen_eff      <= bus.req_widen & (bus.req_sew != SEW_64);
      out_valid      <= 1'b1;
      out_last       <= ~(bus.req_widen & (bus.req_sew != SEW_64));
      out_illegal    <= bus.req_widen & (bus.req_sew == SEW_64);
      wid_turn       <= 1'b0;
      bus.wid_vec0   <= bus.req_vec0;
      bus.wid_vec1   <= bus.req_vec1;
      bus.wid_sew    <= bus.req_sew;
      bus.wid_signed <= bus.req_signed;
      bus.wid_be     <= bus.req_be;
    end else if (beat_done) begin
      if (state == LO && widen_eff) begin
        state    <= HI;
        wid_turn <= 1'b1;
        out_last <= 1'b1;
      end else begin
        // Operand registers keep their last values while idle.
        state       <= IDLE;
        out_valid   <= 1'b0;
        out_last    <= 1'b0;
        out_illegal <= 1'b0;
        wid_turn    <= 1'b0;
      end
    end
  end
endmodule
